// File: rtl/rr_arbiter8_if.sv
// rtl/rr_arbiter8_if.sv - request/grant bundle between requesters and the 8-way round-robin arbiter
//
// Signals:
//   en          requester side -> arbiter : 1 = new grants allowed
//   req[7:0]    requester side -> arbiter : per-requester request, held while owning
//   gnt[7:0]    arbiter -> requester side : registered one-hot grant, zero when idle
//   gnt_idx     arbiter -> requester side : binary index of current/last owner
//   gnt_valid   arbiter -> requester side : an owner currently holds the grant
//   timeout_err arbiter -> requester side : 1-cycle pulse on a forced release
// Modports: master = requester side, slave = arbiter.

interface rr_arbiter8_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout_err;

    modport master (
        output en, req,
        input  gnt, gnt_idx, gnt_valid, timeout_err
    );

    modport slave (
        input  en, req,
        output gnt, gnt_idx, gnt_valid, timeout_err
    );
endinterface

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with hold-until-release ownership
//
// Ports:
//   clk    in  single clock, all state on rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    rr_arbiter8_if.slave (en, req in; gnt, gnt_idx, gnt_valid, timeout_err out)
// Parameters:
//   MAX_HOLD  max cycles one owner may hold the grant (>= 2), used only with ARB_HOLD_TIMEOUT_EN
//   TW        hold counter width, 2**TW > MAX_HOLD
// Optional feature macro: ARB_HOLD_TIMEOUT_EN (forced release after MAX_HOLD cycles).
// Sequence per grant: IDLE (arbitrate) -> GRANT (held while owner req) -> RELEASE (dead cycle) -> IDLE.

module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int TW       = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter8_if.slave bus
);

    if (MAX_HOLD < 2 || (2 ** TW) <= MAX_HOLD) begin : g_param_check
        $error("rr_arbiter8: need MAX_HOLD >= 2 and 2**TW > MAX_HOLD");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [2:0] ptr, ptr_nx;
    logic [2:0] idx, idx_nx;
    logic [7:0] gnt_q, gnt_nx;
    logic       valid_q, valid_nx;
    logic       terr_q, terr_nx;
    logic [2:0] winner;
    logic       owner_req;
    logic       force_rel;

    // Lowest offset from ptr wins: scan from the far end so nearer hits overwrite.
    always_comb begin : pick
        winner = ptr;
        for (int i = 7; i >= 0; i--) begin
            if (bus.req[ptr + 3'(i)]) winner = ptr + 3'(i);
        end
    end

    assign owner_req = bus.req[idx];

`ifdef ARB_HOLD_TIMEOUT_EN
    logic [TW-1:0] hold_cnt, hold_nx;
    // hold_cnt counts completed GRANT cycles after the first, so MAX_HOLD-1 means
    // the owner has had MAX_HOLD cycles of grant.
    assign force_rel = owner_req && (hold_cnt == TW'(MAX_HOLD - 1));
`else
    assign force_rel = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.en && |bus.req) state_nx = GRANT;
            GRANT:   if (!owner_req || force_rel) state_nx = RELEASE;
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output / datapath next values; all outputs leave the block from flops.
    always_comb begin
        ptr_nx   = ptr;
        idx_nx   = idx;
        gnt_nx   = gnt_q;
        valid_nx = valid_q;
        terr_nx  = 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
        hold_nx  = hold_cnt;
`endif
        case (state)
            IDLE: begin
                if (state_nx == GRANT) begin
                    idx_nx   = winner;
                    gnt_nx   = 8'b1 << winner;
                    valid_nx = 1'b1;
`ifdef ARB_HOLD_TIMEOUT_EN
                    hold_nx  = '0;
`endif
                end else begin
                    gnt_nx   = 8'h00;
                    valid_nx = 1'b0;
                end
            end
            GRANT: begin
                if (state_nx == RELEASE) begin
                    gnt_nx   = 8'h00;
                    valid_nx = 1'b0;
                    ptr_nx   = idx + 3'd1;
                    terr_nx  = force_rel;
                end
`ifdef ARB_HOLD_TIMEOUT_EN
                else if (hold_cnt != TW'(MAX_HOLD)) begin
                    hold_nx = hold_cnt + 1'b1;
                end
`endif
            end
            default: begin
                gnt_nx   = 8'h00;
                valid_nx = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= 3'd0;
            idx      <= 3'd0;
            gnt_q    <= 8'h00;
            valid_q  <= 1'b0;
            terr_q   <= 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
            ptr      <= ptr_nx;
            idx      <= idx_nx;
            gnt_q    <= gnt_nx;
            valid_q  <= valid_nx;
            terr_q   <= terr_nx;
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_cnt <= hold_nx;
`endif
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.gnt_idx     = idx;
    assign bus.gnt_valid   = valid_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed self-checking bench for rr_arbiter8

module tb_rr_arbiter8;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    rr_arbiter8_if bus();

    rr_arbiter8 #(.MAX_HOLD(4), .TW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = 8'h00;
        bus.en  = 1'b1;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.req = 8'hFF;
        bus.en  = 1'b1;
        step();
        step();
        total++; if (bus.gnt !== 8'h00) $display("FAIL rst_gnt: got %h want 00", bus.gnt); else passed++;
        total++; if (bus.gnt_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.gnt_valid); else passed++;
        total++; if (bus.gnt_idx !== 3'd0) $display("FAIL rst_idx: got %0d want 0", bus.gnt_idx); else passed++;
        total++; if (bus.timeout_err !== 1'b0) $display("FAIL rst_terr: got %b want 0", bus.timeout_err); else passed++;
        rst_n = 1'b1;
        step();
        total++; if (bus.gnt !== 8'h01) $display("FAIL rst_first_gnt: got %h want 01", bus.gnt); else passed++;
        bus.req = 8'hFE;
        step();
        bus.req = 8'hFF;
        step();
        step();
        total++; if (bus.gnt !== 8'h02) $display("FAIL rst_second_gnt: got %h want 02", bus.gnt); else passed++;
        // Asynchronous clear in the middle of the cycle while owner 1 holds
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.gnt !== 8'h00) $display("FAIL rst_async_gnt: got %h want 00", bus.gnt); else passed++;
        total++; if (bus.gnt_valid !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", bus.gnt_valid); else passed++;
        total++; if (bus.gnt_idx !== 3'd0) $display("FAIL rst_async_idx: got %0d want 0", bus.gnt_idx); else passed++;
        step();
        rst_n = 1'b1;
        step();
        // Priority pointer back at 0 after reset
        total++; if (bus.gnt !== 8'h01) $display("FAIL rst_ptr_zero: got %h want 01", bus.gnt); else passed++;
        bus.req = 8'h00;
        step(); step(); step();
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 8'h20;
        step();
        total++; if (bus.gnt !== 8'h20) $display("FAIL single_gnt: got %h want 20", bus.gnt); else passed++;
        total++; if (bus.gnt_idx !== 3'd5) $display("FAIL single_idx: got %0d want 5", bus.gnt_idx); else passed++;
        total++; if (bus.gnt_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", bus.gnt_valid); else passed++;
        step();
        total++; if (bus.gnt !== 8'h20) $display("FAIL single_hold: got %h want 20", bus.gnt); else passed++;
        bus.req = 8'h00;
        step();
        total++; if (bus.gnt !== 8'h00) $display("FAIL single_release_gnt: got %h want 00", bus.gnt); else passed++;
        total++; if (bus.gnt_valid !== 1'b0) $display("FAIL single_release_valid: got %b want 0", bus.gnt_valid); else passed++;
        total++; if (bus.gnt_idx !== 3'd5) $display("FAIL single_idx_kept: got %0d want 5", bus.gnt_idx); else passed++;
        step();
        // ptr now 6: with requesters 0 and 6 pending, 6 must win
        bus.req = 8'h41;
        step();
        total++; if (bus.gnt !== 8'h40) $display("FAIL single_ptr6: got %h want 40", bus.gnt); else passed++;
        bus.req = 8'h00;
        step(); step(); step();
    endtask

    task automatic test_rotate();
        logic [7:0] want;
        bit         bad;
        do_reset();
        bad = 1'b0;
        bus.req = 8'hFF;
        step();
        for (int k = 0; k < 9; k++) begin
            want = 8'b1 << (k % 8);
            total++;
            if (bus.gnt !== want) $display("FAIL rotate_%0d: got %h want %h", k, bus.gnt, want);
            else passed++;
            step();
            bus.req = 8'hFF & ~want;
            step();
            if (bus.gnt !== 8'h00) bad = 1'b1;
            bus.req = 8'hFF;
            step();
            if (bus.gnt !== 8'h00) bad = 1'b1;
            step();
        end
        total++; if (bad !== 1'b0) $display("FAIL rotate_gap: got overlap %b want 0", bad); else passed++;
        bus.req = 8'h00;
        step(); step(); step();
    endtask

    task automatic test_ignore_others();
        do_reset();
        bus.req = 8'h08;
        step();
        total++; if (bus.gnt !== 8'h08) $display("FAIL ign_owner3: got %h want 08", bus.gnt); else passed++;
        bus.req = 8'h4A;
        step();
        step();
        total++; if (bus.gnt !== 8'h08) $display("FAIL ign_hold3: got %h want 08", bus.gnt); else passed++;
        bus.req = 8'h42;
        step(); step(); step();
        total++; if (bus.gnt !== 8'h40) $display("FAIL ign_next6: got %h want 40", bus.gnt); else passed++;
        bus.req = 8'h02;
        step(); step(); step();
        total++; if (bus.gnt !== 8'h02) $display("FAIL ign_then1: got %h want 02", bus.gnt); else passed++;
        bus.req = 8'h00;
        step(); step(); step();
    endtask

    task automatic test_enable();
        do_reset();
        bus.req = 8'h04;
        step();
        bus.en = 1'b0;
        step(); step();
        total++; if (bus.gnt !== 8'h04) $display("FAIL en_hold: got %h want 04", bus.gnt); else passed++;
        bus.req = 8'h10;
        step();
        total++; if (bus.gnt !== 8'h00) $display("FAIL en_release: got %h want 00", bus.gnt); else passed++;
        step(); step(); step();
        total++; if (bus.gnt !== 8'h00) $display("FAIL en_blocked: got %h want 00", bus.gnt); else passed++;
        total++; if (bus.gnt_valid !== 1'b0) $display("FAIL en_blocked_valid: got %b want 0", bus.gnt_valid); else passed++;
        bus.en = 1'b1;
        step();
        total++; if (bus.gnt !== 8'h10) $display("FAIL en_resume: got %h want 10", bus.gnt); else passed++;
        total++; if (bus.gnt_idx !== 3'd4) $display("FAIL en_resume_idx: got %0d want 4", bus.gnt_idx); else passed++;
        bus.req = 8'h00;
        step(); step(); step();
    endtask

    task automatic test_hold_timeout();
        bit terr_seen;
        do_reset();
        terr_seen = 1'b0;
        bus.req = 8'h01;
        step();
        total++; if (bus.gnt !== 8'h01) $display("FAIL hold_first: got %h want 01", bus.gnt); else passed++;
        bus.req = 8'h11;
`ifdef ARB_HOLD_TIMEOUT_EN
        step(); step(); step();
        total++; if (bus.gnt !== 8'h01) $display("FAIL hold_cycle4: got %h want 01", bus.gnt); else passed++;
        step();
        total++; if (bus.gnt !== 8'h00) $display("FAIL hold_forced: got %h want 00", bus.gnt); else passed++;
        total++; if (bus.timeout_err !== 1'b1) $display("FAIL hold_terr: got %b want 1", bus.timeout_err); else passed++;
        step();
        total++; if (bus.timeout_err !== 1'b0) $display("FAIL hold_terr_pulse: got %b want 0", bus.timeout_err); else passed++;
        step();
        total++; if (bus.gnt !== 8'h10) $display("FAIL hold_next4: got %h want 10", bus.gnt); else passed++;
`else
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.timeout_err !== 1'b0) terr_seen = 1'b1;
        end
        total++; if (bus.gnt !== 8'h01) $display("FAIL hold_unbounded: got %h want 01", bus.gnt); else passed++;
        total++; if (terr_seen !== 1'b0) $display("FAIL hold_no_terr: got %b want 0", terr_seen); else passed++;
`endif
        bus.req = 8'h00;
        step(); step(); step();
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        rst_n   = 1'b0;
        bus.req = 8'h00;
        bus.en  = 1'b1;
        test_reset();
        test_single();
        test_rotate();
        test_ignore_others();
        test_enable();
        test_hold_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
